// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 0-cycle combinational hit, whole-line
// refill from instruction memory one word per MEM_LATENCY cycles on a miss.
module icache #(
  parameter int unsigned NUM_LINES   = 16,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst,
  output logic        inst_ready,
  input  logic        flush,
  input  logic        halted,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [7:0]  imem_data [0:3],
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WOFF_W = $clog2(LINE_WORDS);
  localparam int unsigned WC_W   = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = 30 - WOFF_W - IDX_W;
  localparam int unsigned WT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(MEM_LATENCY - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       line_tag_q, line_tag_d;
  logic [IDX_W-1:0]       line_idx_q, line_idx_d;
  logic [WC_W-1:0]        word_cnt_q, word_cnt_d;
  logic [WT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]            hit_q, hit_d;
  logic [31:0]            miss_q, miss_d;

  // Word-offset field is one bit wide even for single-word lines; it then stays 0.
  logic [31:0]            data_q [2**(IDX_W+WC_W)];
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [WC_W-1:0]        woff;
  logic                   lookup_hit;
  logic                   fill_we;
  logic                   tag_we;
  logic [31:0]            fill_word;
  logic [31:0]            line_base;

  assign idx        = inst_addr[2+WOFF_W +: IDX_W];
  assign tag        = inst_addr[31 -: TAG_W];
  assign woff       = (WOFF_W > 0) ? inst_addr[2 +: WC_W] : '0;
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign inst_ready = (state_q == IDLE) && lookup_hit && !flush;
  assign inst       = inst_ready ? data_q[{idx, woff}] : '0;
  assign fill_word  = {imem_data[0], imem_data[1], imem_data[2], imem_data[3]};
  assign line_base  = {line_tag_q, line_idx_q, (WOFF_W+2)'(0)};
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      line_tag_q <= '0;
      line_idx_q <= '0;
      word_cnt_q <= '0;
      wait_cnt_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      line_tag_q <= line_tag_d;
      line_idx_q <= line_idx_d;
      word_cnt_q <= word_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) data_q[{line_idx_q, word_cnt_q}] <= fill_word;
    if (tag_we)  tag_q[line_idx_q] <= line_tag_q;
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    line_tag_d = line_tag_q;
    line_idx_d = line_idx_q;
    word_cnt_d = word_cnt_q;
    wait_cnt_d = wait_cnt_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    imem_rd_en = 1'b0;
    imem_addr  = '0;
    fill_we    = 1'b0;
    tag_we     = 1'b0;

    if (inst_ready && (hit_q != '1)) hit_d = hit_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (!lookup_hit && !halted) begin
          state_d      = FILL;
          line_tag_d   = tag;
          line_idx_d   = idx;
          valid_d[idx] = 1'b0;
          word_cnt_d   = '0;
          wait_cnt_d   = '0;
          if (miss_q != '1) miss_d = miss_q + 32'd1;
        end
      end
      FILL: begin
        imem_rd_en = 1'b1;
        imem_addr  = line_base | (32'(word_cnt_q) << 2);
        if (flush) begin
          state_d = IDLE;
          valid_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          fill_we    = 1'b1;
          wait_cnt_d = '0;
          if (word_cnt_q == WORD_LAST) begin
            tag_we              = 1'b1;
            valid_d[line_idx_q] = 1'b1;
            state_d             = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: refill timing, hits, conflicts, flush, halt and reset.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        inst_ready;
  logic        flush;
  logic        halted;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [7:0]  imem_data [0:3];
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  icache #(.NUM_LINES(16), .LINE_WORDS(4), .MEM_LATENCY(2)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .inst_addr  (inst_addr),
    .inst       (inst),
    .inst_ready (inst_ready),
    .flush      (flush),
    .halted     (halted),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_data  (imem_data),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  logic [31:0] mem_word;
  always_comb begin
    mem_word     = memf(imem_addr);
    imem_data[0] = mem_word[31:24];
    imem_data[1] = mem_word[23:16];
    imem_data[2] = mem_word[15:8];
    imem_data[3] = mem_word[7:0];
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called on the first FILL cycle; walks the whole refill and ends in IDLE.
  task automatic fill(input logic [31:0] base);
    for (int k = 0; k < 8; k++) begin
      check("fill_rd_en", {31'd0, imem_rd_en}, 32'd1);
      check("fill_addr", imem_addr, base + 32'(4 * (k / 2)));
      check("fill_ready", {31'd0, inst_ready}, 32'd0);
      tick();
    end
    check("fill_done_rd_en", {31'd0, imem_rd_en}, 32'd0);
  endtask

  task automatic expect_hit(input logic [31:0] a);
    inst_addr = a;
    #1;
    check("hit_ready", {31'd0, inst_ready}, 32'd1);
    check("hit_inst", inst, memf(a));
    check("hit_no_rd", {31'd0, imem_rd_en}, 32'd0);
  endtask

  task automatic expect_miss(input logic [31:0] a);
    inst_addr = a;
    #1;
    check("miss_ready", {31'd0, inst_ready}, 32'd0);
    check("miss_inst", inst, 32'd0);
  endtask

  initial begin
    rst_b = 1'b0; inst_addr = '0; flush = 1'b0; halted = 1'b0;
    #1;
    check("rst_ready", {31'd0, inst_ready}, 32'd0);
    check("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_miss", miss_count, 32'd0);

    @(negedge clk);
    rst_b = 1'b1;
    expect_miss(32'h0);
    tick();
    fill(32'h0);
    expect_hit(32'h0);
    check("miss_after_first", miss_count, 32'd1);
    check("hits_before_edge", hit_count, 32'd0);
    tick();
    expect_hit(32'h4); tick();
    expect_hit(32'h8); tick();
    expect_hit(32'hC); tick();
    check("hits_four", hit_count, 32'd4);

    // Conflict on index 0
    expect_miss(32'h100);
    tick();
    fill(32'h100);
    expect_hit(32'h10C);
    tick();
    expect_miss(32'h0);
    tick();
    fill(32'h0);
    expect_hit(32'h8);
    check("miss_conflict", miss_count, 32'd3);
    check("hits_conflict", hit_count, 32'd5);
    tick();

    // Flush mid-refill of 0x40
    expect_miss(32'h40);
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    check("flush_fill_rd_en", {31'd0, imem_rd_en}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    check("flush_idle_rd_en", {31'd0, imem_rd_en}, 32'd0);
    check("flush_idle_addr", imem_addr, 32'd0);
    check("flush_40_miss", {31'd0, inst_ready}, 32'd0);
    check("flush_miss_cnt", miss_count, 32'd4);
    tick();
    check("refill_40_cnt", miss_count, 32'd5);
    fill(32'h40);
    expect_hit(32'h44);
    expect_miss(32'h0);
    tick();
    fill(32'h0);
    check("miss_after_flush", miss_count, 32'd6);

    // Flush in IDLE masks a hit that cycle and invalidates
    expect_hit(32'h4);
    flush = 1'b1;
    #1;
    check("flush_masks_ready", {31'd0, inst_ready}, 32'd0);
    tick();
    flush = 1'b0;
    expect_miss(32'h4);
    expect_miss(32'h44);

    // Halted: no refill starts
    halted = 1'b1;
    expect_miss(32'h200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_no_rd", {31'd0, imem_rd_en}, 32'd0);
    end
    check("halt_miss_cnt", miss_count, 32'd6);
    halted = 1'b0;
    #1;
    tick();
    halted = 1'b1;
    fill(32'h200);
    expect_hit(32'h204);
    check("halt_rise_miss_cnt", miss_count, 32'd7);
    halted = 1'b0;

    // Reset mid-fill
    expect_miss(32'h0);
    tick();
    fill(32'h0);
    expect_hit(32'h0);
    expect_miss(32'h300);
    tick();
    tick();
    tick();
    check("pre_rst_rd_en", {31'd0, imem_rd_en}, 32'd1);
    rst_b = 1'b0;
    #1;
    check("mid_rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    check("mid_rst_miss", miss_count, 32'd0);
    check("mid_rst_hits", hit_count, 32'd0);
    tick();
    rst_b = 1'b1;
    expect_miss(32'h0);
    expect_miss(32'h300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
